// File: rtl/instruction_fetch.sv
// IF stage and IF/ID pipeline register: PC, req/valid instruction-memory fetch, branch redirect.
// Optional fetch/bubble performance counters are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [31:0] branch_imm_ext,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [15:0] if_id_imm,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        new_word;
  logic [31:0] new_instr;

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = branch_pc4 + (branch_imm_ext << 2);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    hold_buf_d = hold_buf_q;
    new_word   = 1'b0;
    new_instr  = imem_rdata;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_valid) begin
          if (branch_taken) begin
            pc_d = target;
          end else if (!stall) begin
            new_word = 1'b1;
            pc_d     = pc_plus4;
          end else begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end
        end else if (branch_taken) begin
          redirect_d = target;
          state_d    = DROP;
        end
      end
      HOLD: begin
        // A redirect wins over a stalled word parked in the buffer.
        if (branch_taken) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!stall) begin
          new_word  = 1'b1;
          new_instr = hold_buf_q;
          pc_d      = pc_plus4;
          state_d   = REQ;
        end
      end
      DROP: begin
        // The old request must still complete before fetching at the redirect target.
        if (imem_valid) begin
          pc_d    = branch_taken ? target : redirect_q;
          state_d = REQ;
        end else if (branch_taken) begin
          redirect_d = target;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == REQ) || (state_d == DROP);

    valid_d = 1'b0;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush || branch_taken) begin
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (new_word) begin
      valid_d = 1'b1;
      instr_d = new_instr;
      pc4_d   = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      redirect_q <= 32'h0;
      hold_buf_q <= 32'h0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      pc4_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      hold_buf_q <= hold_buf_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_imm   = instr_q[15:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        fetch_inc;
  logic        bubble_inc;

  // A bubble is any edge where IF/ID neither holds under stall nor takes a new word.
  always_comb begin
    fetch_inc    = new_word && !flush && !branch_taken && !stall;
    bubble_inc   = !fetch_inc && !(stall && !flush && !branch_taken);
    fetch_cnt_d  = fetch_cnt_q + {31'd0, fetch_inc};
    bubble_cnt_d = bubble_cnt_q + {31'd0, bubble_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, wait states, stall/hold, branch redirect,
// flush, mid-fetch reset, PC wrap and the performance counters.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [31:0] branch_imm_ext;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [15:0] if_id_imm;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;

  int total;
  int bad;
  logic [31:0] expFetch;
  logic [31:0] expBubble;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_pc4     (branch_pc4),
    .branch_imm_ext (branch_imm_ext),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .if_id_imm      (if_id_imm),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, take the rising edge, and land 1 time unit after it.
  task automatic applyStimulus(input logic vld, input logic [31:0] rdata, input logic stl,
                               input logic fls, input logic br, input logic [31:0] bpc4,
                               input logic [31:0] bimm);
    imem_valid     = vld;
    imem_rdata     = rdata;
    stall          = stl;
    flush          = fls;
    branch_taken   = br;
    branch_pc4     = bpc4;
    branch_imm_ext = bimm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    imem_valid = 1'b0; imem_rdata = 32'h0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_pc4 = 32'h0; branch_imm_ext = 32'h0;

    #12;
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("rst_instr", if_id_instr, 32'h0);
    checkOutput("rst_pc4", if_id_pc4, 32'h0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("idle2req_req", {31'd0, imem_req}, 32'd1);
    checkOutput("idle2req_addr", imem_addr, 32'h0);
    checkOutput("idle2req_valid", {31'd0, if_id_valid}, 32'd0);

    // zero-wait streaming, memory returns address as data
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("s0_valid", {31'd0, if_id_valid}, 32'd1);
    checkOutput("s0_instr", if_id_instr, 32'h0);
    checkOutput("s0_pc4", if_id_pc4, 32'h4);
    checkOutput("s0_addr", imem_addr, 32'h4);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("s1_instr", if_id_instr, 32'h4);
    checkOutput("s1_pc4", if_id_pc4, 32'h8);
    checkOutput("s1_addr", imem_addr, 32'h8);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("s2_instr", if_id_instr, 32'h8);
    checkOutput("s2_pc4", if_id_pc4, 32'hC);
    checkOutput("s2_addr", imem_addr, 32'hC);

    // two wait states at pc=0xC
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("w0_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("w0_addr", imem_addr, 32'hC);
    checkOutput("w0_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("w1_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("w1_addr", imem_addr, 32'hC);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("w2_valid", {31'd0, if_id_valid}, 32'd1);
    checkOutput("w2_instr", if_id_instr, 32'hC);
    checkOutput("w2_pc4", if_id_pc4, 32'h10);
    checkOutput("w2_addr", imem_addr, 32'h10);

    // stall while the word at pc=0x10 returns
    applyStimulus(1'b1, 32'hAAAA_0010, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("h0_req", {31'd0, imem_req}, 32'd0);
    checkOutput("h0_instr", if_id_instr, 32'hC);
    checkOutput("h0_valid", {31'd0, if_id_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("h1_req", {31'd0, imem_req}, 32'd0);
    checkOutput("h1_instr", if_id_instr, 32'hC);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("h2_pc4", if_id_pc4, 32'h10);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("h3_instr", if_id_instr, 32'hAAAA_0010);
    checkOutput("h3_pc4", if_id_pc4, 32'h14);
    checkOutput("h3_valid", {31'd0, if_id_valid}, 32'd1);
    checkOutput("h3_addr", imem_addr, 32'h14);
    checkOutput("h3_req", {31'd0, imem_req}, 32'd1);

    // branch while waiting: 0x20 + (-4 << 2) = 0x10
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hFFFF_FFFC);
    checkOutput("b0_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("b0_addr", imem_addr, 32'h14);
    checkOutput("b0_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("b1_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("b1_addr", imem_addr, 32'h10);
    checkOutput("b1_instr", if_id_instr, 32'hAAAA_0010);

    // branch together with valid: 0x0 + (-1 << 2) = 0xFFFF_FFFC
    applyStimulus(1'b1, 32'h1111, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
    checkOutput("bv_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("bv_addr", imem_addr, 32'hFFFF_FFFC);

    // fetch at the top of the address space wraps
    applyStimulus(1'b1, 32'h1234_CAFE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wrap_instr", if_id_instr, 32'h1234_CAFE);
    checkOutput("wrap_pc4", if_id_pc4, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkOutput("wrap_imm", {16'd0, if_id_imm}, 32'h0000_CAFE);

    // flush and stall together
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("fs_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("fs_req", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("fs_rel_instr", if_id_instr, 32'h55);
    checkOutput("fs_rel_pc4", if_id_pc4, 32'h4);
    checkOutput("fs_rel_addr", imem_addr, 32'h4);

    // async reset in the middle of a request
    rst_n = 1'b0;
    #1;
    checkOutput("mr_req", {31'd0, imem_req}, 32'd0);
    checkOutput("mr_addr", imem_addr, 32'h0);
    checkOutput("mr_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("mr_instr", if_id_instr, 32'h0);
    checkOutput("mr_pc4", if_id_pc4, 32'h0);
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("mr_idle_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("mr_idle_req", {31'd0, imem_req}, 32'd1);
    checkOutput("mr_idle_addr", imem_addr, 32'h0);

    // ten fetches with two wait states in the middle
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("pl_wait_valid", {31'd0, if_id_valid}, 32'd0);
        checkOutput("pl_wait_addr", imem_addr, 32'h14);
      end
      applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("pl_instr", if_id_instr, 32'(i * 4));
      checkOutput("pl_pc4", if_id_pc4, 32'(i * 4 + 4));
    end

`ifdef FETCH_PERF_CNT_EN
    expFetch  = 32'd10;
    expBubble = 32'd3;
`else
    expFetch  = 32'd0;
    expBubble = 32'd0;
`endif
    checkOutput("perf_fetch", perf_fetch_cnt, expFetch);
    checkOutput("perf_bubble", perf_bubble_cnt, expBubble);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
